// File: rtl/parallelizer_mono8.sv
// Packs a frame of Mono8 pixels (one per clock) into 256-bit AXI-Stream words of 32 pixels.
// Optional macro PARALLELIZER_SOF_TUSER_EN adds m_axis_tuser, set on the first word of each frame.
module parallelizer_mono8 #(
  parameter int IN_ROWS = 20,
  parameter int IN_COLS = 20
) (
  input  logic         clk,
  input  logic         s_axis_resetn,
  input  logic         ap_start,
  output logic         ap_ready,
  output logic         ap_idle,
  output logic         ap_done,
  input  logic         s_axis_tvalid,
  output logic         s_axis_tready,
  input  logic [7:0]   s_axis_tdata,
  output logic         m_axis_tvalid,
  input  logic         m_axis_tready,
  output logic [255:0] m_axis_tdata,
  output logic [31:0]  m_axis_tkeep,
  output logic         m_axis_tlast
`ifdef PARALLELIZER_SOF_TUSER_EN
  ,
  output logic         m_axis_tuser
`endif
);

  localparam int N     = IN_ROWS * IN_COLS;
  localparam int PIX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [PIX_W-1:0] LAST_PIX = PIX_W'(N - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PACK = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_reg, state_next;
  logic [4:0]       cnt_byte_reg;
  logic [PIX_W-1:0] cnt_pix_reg;
  logic             pix_done_reg;
  logic [7:0]       lane_reg [32];
  logic [255:0]     word_data;
  logic [31:0]      word_keep;

  logic [255:0]     tdata_reg;
  logic [31:0]      tkeep_reg;
  logic             tlast_reg;
  logic             out_valid_reg;

  logic start_frame, closes, pix_hs, word_load, out_hs;

  assign start_frame = (state_reg == S_IDLE) && ap_start;
  assign closes      = (cnt_byte_reg == 5'd31) || (cnt_pix_reg == LAST_PIX);
  // Only the closing pixel needs a free output slot, so only it waits on the master.
  assign s_axis_tready = (state_reg == S_PACK) && !pix_done_reg &&
                         !(closes && out_valid_reg && !m_axis_tready);
  assign pix_hs    = s_axis_tvalid && s_axis_tready;
  assign word_load = pix_hs && closes;
  assign out_hs    = out_valid_reg && m_axis_tready;

  assign ap_idle  = (state_reg == S_IDLE);
  assign ap_ready = (state_reg == S_IDLE);
  assign ap_done  = (state_reg == S_DONE);

  assign m_axis_tvalid = out_valid_reg;
  assign m_axis_tdata  = tdata_reg;
  assign m_axis_tkeep  = tkeep_reg;
  assign m_axis_tlast  = tlast_reg;

  // The closing pixel bypasses its lane straight into the outgoing word.
  genvar gi;
  generate
    for (gi = 0; gi < 32; gi++) begin : g_lane
      always_ff @(posedge clk or negedge s_axis_resetn) begin
        if (!s_axis_resetn) begin
          lane_reg[gi] <= 8'h00;
        end else if (start_frame || word_load) begin
          lane_reg[gi] <= 8'h00;
        end else if (pix_hs && (cnt_byte_reg == 5'(gi))) begin
          lane_reg[gi] <= s_axis_tdata;
        end
      end
      assign word_data[8*gi +: 8] = (cnt_byte_reg == 5'(gi)) ? s_axis_tdata : lane_reg[gi];
      assign word_keep[gi]        = (5'(gi) <= cnt_byte_reg);
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (ap_start) state_next = S_PACK;
      S_PACK:  if (out_hs && tlast_reg) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge s_axis_resetn) begin
    if (!s_axis_resetn) begin
      state_reg    <= S_IDLE;
      cnt_byte_reg <= 5'd0;
      cnt_pix_reg  <= '0;
      pix_done_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (start_frame) begin
        cnt_byte_reg <= 5'd0;
        cnt_pix_reg  <= '0;
        pix_done_reg <= 1'b0;
      end else if (pix_hs) begin
        cnt_byte_reg <= word_load ? 5'd0 : cnt_byte_reg + 5'd1;
        if (cnt_pix_reg == LAST_PIX) begin
          pix_done_reg <= 1'b1;
        end else begin
          cnt_pix_reg <= cnt_pix_reg + PIX_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge s_axis_resetn) begin
    if (!s_axis_resetn) begin
      tdata_reg     <= '0;
      tkeep_reg     <= '0;
      tlast_reg     <= 1'b0;
      out_valid_reg <= 1'b0;
    end else if (word_load) begin
      tdata_reg     <= word_data;
      tkeep_reg     <= word_keep;
      tlast_reg     <= (cnt_pix_reg == LAST_PIX);
      out_valid_reg <= 1'b1;
    end else if (out_hs) begin
      out_valid_reg <= 1'b0;
    end
  end

`ifdef PARALLELIZER_SOF_TUSER_EN
  logic first_word_reg;
  logic tuser_reg;

  always_ff @(posedge clk or negedge s_axis_resetn) begin
    if (!s_axis_resetn) begin
      first_word_reg <= 1'b0;
      tuser_reg      <= 1'b0;
    end else if (start_frame) begin
      first_word_reg <= 1'b1;
    end else if (word_load) begin
      first_word_reg <= 1'b0;
      tuser_reg      <= first_word_reg;
    end
  end

  assign m_axis_tuser = tuser_reg;
`endif

endmodule

// File: tb/tb_parallelizer_mono8.sv
// Directed bench for parallelizer_mono8: an 8x8 instance for the main frames and a 5x5 instance
// for the partial final word.
module tb_parallelizer_mono8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  logic a_start, a_ready, a_idle, a_done, a_svalid, a_sready, a_mvalid, a_mready, a_mlast;
  logic [7:0]   a_sdata;
  logic [255:0] a_mdata;
  logic [31:0]  a_mkeep;
  logic b_start, b_ready, b_idle, b_done, b_svalid, b_sready, b_mvalid, b_mready, b_mlast;
  logic [7:0]   b_sdata;
  logic [255:0] b_mdata;
  logic [31:0]  b_mkeep;
`ifdef PARALLELIZER_SOF_TUSER_EN
  logic a_muser, b_muser;
`endif

  parallelizer_mono8 #(.IN_ROWS(8), .IN_COLS(8)) dut_a (
    .clk(clk), .s_axis_resetn(rst_n),
    .ap_start(a_start), .ap_ready(a_ready), .ap_idle(a_idle), .ap_done(a_done),
    .s_axis_tvalid(a_svalid), .s_axis_tready(a_sready), .s_axis_tdata(a_sdata),
    .m_axis_tvalid(a_mvalid), .m_axis_tready(a_mready), .m_axis_tdata(a_mdata),
    .m_axis_tkeep(a_mkeep), .m_axis_tlast(a_mlast)
`ifdef PARALLELIZER_SOF_TUSER_EN
    , .m_axis_tuser(a_muser)
`endif
  );

  parallelizer_mono8 #(.IN_ROWS(5), .IN_COLS(5)) dut_b (
    .clk(clk), .s_axis_resetn(rst_n),
    .ap_start(b_start), .ap_ready(b_ready), .ap_idle(b_idle), .ap_done(b_done),
    .s_axis_tvalid(b_svalid), .s_axis_tready(b_sready), .s_axis_tdata(b_sdata),
    .m_axis_tvalid(b_mvalid), .m_axis_tready(b_mready), .m_axis_tdata(b_mdata),
    .m_axis_tkeep(b_mkeep), .m_axis_tlast(b_mlast)
`ifdef PARALLELIZER_SOF_TUSER_EN
    , .m_axis_tuser(b_muser)
`endif
  );

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Pixel i of a frame carries (base + i) mod 256; bytes past the frame end are zero.
  function automatic logic [255:0] exp_word(input int base, input int widx, input int npix);
    logic [255:0] w;
    w = '0;
    for (int b = 0; b < 32; b++)
      if (widx * 32 + b < npix) w[8*b +: 8] = 8'(base + widx * 32 + b);
    return w;
  endfunction

  function automatic logic [31:0] exp_keep(input int widx, input int npix);
    logic [32:0] k;
    int rem;
    rem = npix - widx * 32;
    if (rem >= 32) return 32'hFFFF_FFFF;
    k = (33'd1 << rem) - 33'd1;
    return k[31:0];
  endfunction

  // mode 0: full rate; mode 1: master stalled on cycles 10..70; mode 2: random throttling.
  task automatic run_frame8(input int mode, input int base);
    int pix, widx, ntlast, ndone, done_cyc, last_hs_cyc, first_low, low_pix, nlow, unstable;
    logic [255:0] snap_data;
    logic [31:0]  snap_keep;
    logic         snap_last, stall_seen;
    pix = 0; widx = 0; ntlast = 0; ndone = 0; done_cyc = -1; last_hs_cyc = -1;
    first_low = -1; low_pix = -1; nlow = 0; unstable = 0; stall_seen = 1'b0;
    snap_data = '0; snap_keep = '0; snap_last = 1'b0;
    @(negedge clk);
    a_start = 1'b1; a_svalid = 1'b0; a_mready = 1'b1;
    #1;
    chk("ap_ready_at_start", a_ready, 1);
    chk("ap_idle_at_start", a_idle, 1);
    for (int cyc = 0; cyc < 2000; cyc++) begin
      @(negedge clk);
      a_start  = 1'b0;
      a_svalid = (mode == 2) ? ($urandom_range(0, 9) < 7) : 1'b1;
      a_sdata  = 8'(base + pix);
      a_mready = (mode == 1) ? !(cyc >= 10 && cyc <= 70) :
                 (mode == 2) ? ($urandom_range(0, 9) < 7) : 1'b1;
      #1;
      if (a_done) begin
        ndone++;
        done_cyc = cyc;
        break;
      end
      if (a_svalid && !a_sready && pix < 64) begin
        nlow++;
        if (first_low < 0) begin
          first_low = cyc;
          low_pix   = pix;
        end
      end
      if (a_mvalid && !a_mready) begin
        if (stall_seen && (a_mdata !== snap_data || a_mkeep !== snap_keep || a_mlast !== snap_last))
          unstable++;
        snap_data = a_mdata; snap_keep = a_mkeep; snap_last = a_mlast; stall_seen = 1'b1;
      end else begin
        stall_seen = 1'b0;
      end
      if (a_svalid && a_sready) pix++;
      if (a_mvalid && a_mready) begin
        $display("frame base=%02h word %0d cyc=%0d keep=%h last=%0b", base, widx, cyc, a_mkeep, a_mlast);
        chk("word_data", a_mdata, exp_word(base, widx, 64));
        chk("word_keep", a_mkeep, exp_keep(widx, 64));
        chk("word_last", a_mlast, (widx == 1));
`ifdef PARALLELIZER_SOF_TUSER_EN
        chk("word_tuser", a_muser, (widx == 0));
`endif
        if (a_mlast) begin
          ntlast++;
          last_hs_cyc = cyc;
        end
        widx++;
      end
    end
    chk("done_seen", ndone, 1);
    chk("pixels_accepted", pix, 64);
    chk("word_count", widx, 2);
    chk("tlast_count", ntlast, 1);
    chk("axi_stable", unstable, 0);
    if (mode == 0) chk("done_latency", done_cyc, last_hs_cyc + 1);
    if (mode == 1) begin
      chk("stall_first_low_cyc", first_low, 63);
      chk("stall_low_pixel", low_pix, 63);
      chk("stall_low_count", nlow, 8);
    end
    @(negedge clk);
    a_svalid = 1'b0;
    #1;
    chk("done_one_cycle", a_done, 0);
    chk("idle_after_done", a_idle, 1);
  endtask

  initial begin
    logic [255:0] exp5;
    int pix5, got5;

    rst_n = 1'b0;
    a_start = 1'b0; a_svalid = 1'b0; a_sdata = 8'h00; a_mready = 1'b0;
    b_start = 1'b0; b_svalid = 1'b0; b_sdata = 8'h00; b_mready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_ap_idle", a_idle, 1);
    chk("rst_ap_ready", a_ready, 1);
    chk("rst_ap_done", a_done, 0);
    chk("rst_s_tready", a_sready, 0);
    chk("rst_m_tvalid", a_mvalid, 0);
    chk("rst_m_tdata", a_mdata, 0);
    chk("rst_m_tkeep", a_mkeep, 0);
    chk("rst_m_tlast", a_mlast, 0);
    rst_n = 1'b1;

    // 5x5 frame: a single partial word.
    exp5 = '0;
    for (int i = 0; i < 25; i++) exp5[8*i +: 8] = 8'(i);
    pix5 = 0; got5 = 0;
    @(negedge clk);
    b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0; b_svalid = 1'b1; b_mready = 1'b1;
    for (int k = 0; k < 100; k++) begin
      if (k > 0) @(negedge clk);
      b_sdata = 8'(pix5);
      #1;
      if (b_mvalid && b_mready) begin
        $display("frame 5x5 word 0 keep=%h last=%0b", b_mkeep, b_mlast);
        got5 = 1;
        chk("w5_data", b_mdata, exp5);
        chk("w5_keep", b_mkeep, 32'h01FF_FFFF);
        chk("w5_last", b_mlast, 1);
        break;
      end
      if (b_svalid && b_sready) pix5++;
    end
    chk("w5_seen", got5, 1);
    chk("w5_pixels", pix5, 25);
    @(negedge clk);
    b_svalid = 1'b0;
    #1;
    chk("w5_done", b_done, 1);

    run_frame8(0, 0);
    run_frame8(1, 0);
    run_frame8(2, 8'h40);
    run_frame8(2, 8'h55);
    run_frame8(2, 8'hAA);

    // Reset in the middle of a frame with a word pending on the master.
    @(negedge clk);
    a_start = 1'b1;
    pix5 = 0;
    @(negedge clk);
    a_start = 1'b0; a_svalid = 1'b1; a_mready = 1'b0;
    for (int k = 0; k < 200 && pix5 < 41; k++) begin
      if (k > 0) @(negedge clk);
      a_sdata = 8'(8'h80 + pix5);
      #1;
      if (a_svalid && a_sready) pix5++;
    end
    chk("pre_reset_pixels", pix5, 41);
    @(negedge clk);
    a_svalid = 1'b0;
    #1;
    chk("pre_reset_m_tvalid", a_mvalid, 1);
    rst_n = 1'b0;
    #1;
    $display("reset asserted after pixel 40");
    chk("mid_rst_m_tvalid", a_mvalid, 0);
    chk("mid_rst_m_tdata", a_mdata, 0);
    chk("mid_rst_m_tkeep", a_mkeep, 0);
    chk("mid_rst_m_tlast", a_mlast, 0);
    chk("mid_rst_ap_idle", a_idle, 1);
    chk("mid_rst_ap_ready", a_ready, 1);
    chk("mid_rst_ap_done", a_done, 0);
    chk("mid_rst_s_tready", a_sready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_frame8(0, 8'h10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
